// File: rtl/autoplay_pkg.sv
// Shared state codes, reset constants, shuffle LFSR definition and button
// command decoding for the AutoPlay playlist scheduler.
package autoplay_pkg;

    // state   | meaning
    // IDLE    | stopped, all song generators disabled, index retained
    // PLAY    | one song generator enabled, its note code routed out
    // GAP     | silent pause between songs, counting down to PLAY
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0]  REST_CODE_DEF = 8'd100;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 with a right-shifting register
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;

    localparam int BTN_PLAY = 0;
    localparam int BTN_PREV = 1;
    localparam int BTN_NEXT = 2;
    localparam int BTN_STOP = 3;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_PLAY = 3'd1,
        CMD_PREV = 3'd2,
        CMD_NEXT = 3'd3,
        CMD_STOP = 3'd4
    } cmd_t;

    function automatic cmd_t cmd_decode(input logic [3:0] pulse);
        if (pulse[BTN_STOP])      return CMD_STOP;
        else if (pulse[BTN_NEXT]) return CMD_NEXT;
        else if (pulse[BTN_PREV]) return CMD_PREV;
        else if (pulse[BTN_PLAY]) return CMD_PLAY;
        else                      return CMD_NONE;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/autoplay_btn_edge.sv
// Button synchroniser stage: registers the four button levels and emits a
// registered one-cycle pulse for each rising edge.
module autoplay_btn_edge (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic [3:0] i_btn,
    output logic [3:0] o_pulse
);

    logic [3:0] r_btn;
    logic [3:0] r_pulse;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_btn   <= '0;
            r_pulse <= '0;
        end else begin
            r_btn   <= i_btn;
            r_pulse <= i_btn & ~r_btn;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/autoplay_scheduler.sv
// Playlist scheduler: sequences NUM_SONGS song generators with silent gaps.
// Define AUTOPLAY_SHUFFLE_EN for LFSR-driven shuffle order on advance/Next.
module autoplay_scheduler
    import autoplay_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int SEL_W      = 2,
    parameter int GAP_CYCLES = 1905000,
    parameter int END_THRESH = 90,
    parameter int REST_CODE  = 100
) (
    input  logic                   iClk,
    input  logic                   iReset_n,
    input  logic                   iPlay,
    input  logic                   iStop,
    input  logic                   iNext,
    input  logic                   iPrev,
    input  logic                   iRepeatOne,
    input  logic [NUM_SONGS*8-1:0] iSongFreq,
    input  logic [NUM_SONGS*8-1:0] iSongProgress,
    output logic [NUM_SONGS-1:0]   oSongEnable,
    output logic [7:0]             oFreq,
    output logic [7:0]             oProgress,
    output logic [SEL_W-1:0]       oSongIdx,
    output logic [1:0]             oState
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_SONGS - 1);
    localparam logic [7:0]       REST     = 8'(REST_CODE);
    localparam logic [7:0]       THRESH   = 8'(END_THRESH);

    logic [3:0]       w_pulse;
    cmd_t             w_cmd;
    logic [1:0]       r_state, w_state_nx;
    logic [SEL_W-1:0] r_idx, w_idx_nx, w_idx_inc, w_idx_dec, w_idx_adv;
    logic [GAP_W-1:0] r_gap, w_gap_nx;
    logic [7:0]       r_freq, r_progress, w_cur_freq, w_cur_prog;
    logic             r_first, w_end, w_play_hold;

    autoplay_btn_edge u_btn_edge (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .i_btn    ({iStop, iNext, iPrev, iPlay}),
        .o_pulse  (w_pulse)
    );

    assign w_cmd      = cmd_decode(w_pulse);
    assign w_cur_freq = iSongFreq[{r_idx, 3'b000} +: 8];
    assign w_cur_prog = iSongProgress[{r_idx, 3'b000} +: 8];
    assign w_idx_inc  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_idx_dec  = (r_idx == '0) ? IDX_LAST : r_idx - 1'b1;

`ifdef AUTOPLAY_SHUFFLE_EN
    logic [15:0]      r_lfsr;
    logic [SEL_W-1:0] w_pick;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) r_lfsr <= LFSR_SEED;
        else           r_lfsr <= lfsr_step(r_lfsr);
    end

    // Low bits folded into range; never replay the current song.
    assign w_pick    = (r_lfsr[SEL_W-1:0] > IDX_LAST) ? r_lfsr[SEL_W-1:0] - SEL_W'(NUM_SONGS)
                                                      : r_lfsr[SEL_W-1:0];
    assign w_idx_adv = (w_pick == r_idx) ? w_idx_inc : w_pick;
`else
    assign w_idx_adv = w_idx_inc;
`endif

    // A progress drop from near the end marks song completion.
    assign w_end = (r_state == ST_PLAY) && !r_first &&
                   (r_progress >= THRESH) && (w_cur_prog < r_progress);

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_gap_nx   = r_gap;
        if (w_cmd == CMD_STOP) begin
            w_state_nx = ST_IDLE;
        end else if (w_cmd == CMD_NEXT || w_cmd == CMD_PREV) begin
            w_idx_nx = (w_cmd == CMD_NEXT) ? w_idx_adv : w_idx_dec;
            if (r_state != ST_IDLE) begin
                w_state_nx = ST_GAP;
                w_gap_nx   = GAP_LOAD;
            end
        end else begin
            case (r_state)
                ST_IDLE: if (w_cmd == CMD_PLAY) w_state_nx = ST_PLAY;
                ST_PLAY: begin
                    if (w_end) begin
                        w_state_nx = ST_GAP;
                        w_gap_nx   = GAP_LOAD;
                        w_idx_nx   = iRepeatOne ? r_idx : w_idx_adv;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) w_state_nx = ST_PLAY;
                    else             w_gap_nx   = r_gap - 1'b1;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign w_play_hold = (r_state == ST_PLAY) && (w_state_nx == ST_PLAY);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_gap      <= '0;
            r_freq     <= REST;
            r_progress <= '0;
            r_first    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_gap      <= w_gap_nx;
            r_freq     <= w_play_hold ? w_cur_freq : REST;
            r_progress <= w_play_hold ? w_cur_prog : 8'd0;
            r_first    <= (r_state != ST_PLAY) && (w_state_nx == ST_PLAY);
        end
    end

    always_comb begin
        oSongEnable = '0;
        if (r_state == ST_PLAY) oSongEnable[r_idx] = 1'b1;
    end

    assign oFreq     = r_freq;
    assign oProgress = r_progress;
    assign oSongIdx  = r_idx;
    assign oState    = r_state;

endmodule
